// File: rtl/tank_pkg.sv
// Shared tank types: renderer heading encoding, mover states and screen geometry.
package tank_pkg;

  localparam int unsigned SCREEN_W  = 640;
  localparam int unsigned SCREEN_H  = 480;
  localparam int unsigned TANK_SIZE = 28;

  typedef logic [10:0] coord_t;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_LEFT  = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MOVE    = 2'd1,
    ST_BLOCKED = 2'd2
  } state_e;

  // Bit order {up, left, down, right}, matching the renderer direction lines.
  function automatic logic [3:0] dir_onehot(input dir_e d);
    logic [3:0] oh;
    oh = '0;
    case (d)
      DIR_UP:    oh = 4'b1000;
      DIR_LEFT:  oh = 4'b0100;
      DIR_DOWN:  oh = 4'b0010;
      DIR_RIGHT: oh = 4'b0001;
      default:   oh = '0;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/tank_mover_if.sv
// Frame/key/collision inputs and position/direction outputs of one tank mover.
interface tank_mover_if;
  logic        startOfFrame;
  logic        key_up;
  logic        key_left;
  logic        key_down;
  logic        key_right;
  logic        collision;
  logic [10:0] topLeftX;
  logic [10:0] topLeftY;
  logic        upIsPressed;
  logic        leftIsPressed;
  logic        downIsPressed;
  logic        rightIsPressed;
  logic [1:0]  heading;
  logic        moving;

  modport master (
    output startOfFrame, key_up, key_left, key_down, key_right, collision,
    input  topLeftX, topLeftY, upIsPressed, leftIsPressed, downIsPressed,
           rightIsPressed, heading, moving
  );

  modport slave (
    input  startOfFrame, key_up, key_left, key_down, key_right, collision,
    output topLeftX, topLeftY, upIsPressed, leftIsPressed, downIsPressed,
           rightIsPressed, heading, moving
  );
endinterface

// File: rtl/tank_pos_step.sv
// Combinational one-step position update; TANK_MOVER_WRAP_EN selects wrap instead of clamp.
module tank_pos_step #(
  parameter int SPEED = 2,
  parameter int XMAX  = 612,
  parameter int YMAX  = 452
) (
  input  logic [10:0]   x,
  input  logic [10:0]   y,
  input  tank_pkg::dir_e dir,
  output logic [10:0]   nx,
  output logic [10:0]   ny,
  output logic          changed
);
  import tank_pkg::*;

  localparam logic signed [11:0] STEP = 12'(SPEED);
  localparam logic signed [11:0] XLIM = 12'(XMAX);
  localparam logic signed [11:0] YLIM = 12'(YMAX);

  logic signed [11:0] sx;
  logic signed [11:0] sy;

  always_comb begin
    sx = $signed({1'b0, x});
    sy = $signed({1'b0, y});
    case (dir)
      DIR_UP:    sy = sy - STEP;
      DIR_LEFT:  sx = sx - STEP;
      DIR_DOWN:  sy = sy + STEP;
      DIR_RIGHT: sx = sx + STEP;
      default:   ;
    endcase
`ifdef TANK_MOVER_WRAP_EN
    if (sx < 12'sd0)     sx = XLIM;
    else if (sx > XLIM)  sx = '0;
    if (sy < 12'sd0)     sy = YLIM;
    else if (sy > YLIM)  sy = '0;
`else
    if (sx < 12'sd0)     sx = '0;
    else if (sx > XLIM)  sx = XLIM;
    if (sy < 12'sd0)     sy = '0;
    else if (sy > YLIM)  sy = YLIM;
`endif
    nx      = sx[10:0];
    ny      = sy[10:0];
    changed = (nx != x) || (ny != y);
  end

endmodule

// File: rtl/tank_mover.sv
// Per-frame tank motion controller with collision rollback.
// Optional edge wrap-around: define TANK_MOVER_WRAP_EN.
module tank_mover #(
  parameter int INIT_X    = 64,
  parameter int INIT_Y    = 400,
  parameter int SPEED     = 2,
  parameter int TANK_SIZE = tank_pkg::TANK_SIZE,
  parameter int SCREEN_W  = tank_pkg::SCREEN_W,
  parameter int SCREEN_H  = tank_pkg::SCREEN_H
) (
  input  logic        clk,
  input  logic        reset,
  tank_mover_if.slave bus
);
  import tank_pkg::*;

  localparam int XMAX = SCREEN_W - TANK_SIZE;
  localparam int YMAX = SCREEN_H - TANK_SIZE;

  state_e      state_q, state_d;
  coord_t      x_q, x_d, y_q, y_d;
  coord_t      px_q, px_d, py_q, py_d;
  dir_e        hd_q, hd_d, blk_q, blk_d;
  logic [3:0]  lines_q, lines_d;
  logic        mv_q, mv_d;
  logic        hit_q;

  logic [3:0]  keys;
  logic        one_key;
  dir_e        key_dir;
  coord_t      step_x, step_y;
  logic        step_changed;
  logic        hit_now;

  assign keys    = {bus.key_up, bus.key_left, bus.key_down, bus.key_right};
  assign one_key = $onehot(keys);

  always_comb begin
    key_dir = DIR_UP;
    if (bus.key_left)       key_dir = DIR_LEFT;
    else if (bus.key_down)  key_dir = DIR_DOWN;
    else if (bus.key_right) key_dir = DIR_RIGHT;
  end

  tank_pos_step #(
    .SPEED (SPEED),
    .XMAX  (XMAX),
    .YMAX  (YMAX)
  ) u_step (
    .x       (x_q),
    .y       (y_q),
    .dir     (key_dir),
    .nx      (step_x),
    .ny      (step_y),
    .changed (step_changed)
  );

  // A collision on the startOfFrame cycle still counts against the frame just drawn.
  assign hit_now = hit_q | bus.collision;

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    px_d    = px_q;
    py_d    = py_q;
    hd_d    = hd_q;
    blk_d   = blk_q;
    lines_d = lines_q;
    mv_d    = mv_q;
    if (bus.startOfFrame) begin
      lines_d = '0;
      mv_d    = 1'b0;
      if (hit_now && state_q == ST_MOVE) begin
        x_d     = px_q;
        y_d     = py_q;
        blk_d   = hd_q;
        state_d = ST_BLOCKED;
      end else if (one_key && !(state_q == ST_BLOCKED && key_dir == blk_q)) begin
        lines_d = dir_onehot(key_dir);
        hd_d    = key_dir;
        if (step_changed) begin
          px_d    = x_q;
          py_d    = y_q;
          x_d     = step_x;
          y_d     = step_y;
          mv_d    = 1'b1;
          state_d = ST_MOVE;
        end else begin
          state_d = ST_IDLE;
        end
      end else if (state_q == ST_BLOCKED && one_key && key_dir == blk_q) begin
        state_d = ST_BLOCKED;
      end else begin
        state_d = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      x_q     <= 11'(INIT_X);
      y_q     <= 11'(INIT_Y);
      px_q    <= 11'(INIT_X);
      py_q    <= 11'(INIT_Y);
      hd_q    <= DIR_UP;
      blk_q   <= DIR_UP;
      lines_q <= '0;
      mv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      px_q    <= px_d;
      py_q    <= py_d;
      hd_q    <= hd_d;
      blk_q   <= blk_d;
      lines_q <= lines_d;
      mv_q    <= mv_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                 hit_q <= 1'b0;
    else if (bus.startOfFrame) hit_q <= 1'b0;
    else if (bus.collision)    hit_q <= 1'b1;
  end

  assign bus.topLeftX       = x_q;
  assign bus.topLeftY       = y_q;
  assign bus.upIsPressed    = lines_q[3];
  assign bus.leftIsPressed  = lines_q[2];
  assign bus.downIsPressed  = lines_q[1];
  assign bus.rightIsPressed = lines_q[0];
  assign bus.heading        = hd_q;
  assign bus.moving         = mv_q;

endmodule
